// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: shared digit type, BCD limits and integer-to-BCD conversion for the scan counter
package bcd_scan_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// bcd_digit: one BCD digit that steps up or down when its carry/borrow-in is set
module bcd_digit
    import bcd_scan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       wrap_set,
    input  bcd_digit_t wrap_digit,
    input  logic       step,
    input  logic       down,
    input  logic       cin,
    output bcd_digit_t value,
    output logic       cout
);

    assign cout = cin && (down ? value == BCD_MIN : value == BCD_MAX);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            value <= BCD_MIN;
        else if (load)
            value <= load_digit;
        else if (wrap_set)
            value <= wrap_digit;
        else if (step && cin)
            value <= down ? (value == BCD_MIN ? BCD_MAX : value - 1'b1)
                          : (value == BCD_MAX ? BCD_MIN : value + 1'b1);

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled up/down BCD modulus counter with digit scan mux; BCD_SCAN_LEAD_BLANK_EN blanks leading zeros
module bcd_scan_counter
    import bcd_scan_pkg::*;
#(
    parameter int CLK_DIV_INT = 5,
    parameter int NUM_DIGITS  = 2,
    parameter int MODULUS     = 60,
    parameter int SCAN_DIV    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pause,
    input  logic                    down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [3:0]              muxed_digit,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    wrap
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(CLK_DIV_INT);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [15:0]   TOP_FULL  = to_bcd(MODULUS - 1);
    localparam logic [W-1:0]  TOP_BCD   = TOP_FULL[W-1:0];
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV_INT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         pre;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    bcd_digit_t            digits [NUM_DIGITS];
    logic [NUM_DIGITS:0]   carry;
    logic [31:0]           load_int;
    logic                  load_digits_ok;
    logic                  load_ok;
    logic                  tick;
    logic                  wrap_now;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  unused_carry;

    always_comb begin
        load_int = '0;
        load_digits_ok = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            load_digits_ok = load_digits_ok && load_value[4*i +: 4] <= BCD_MAX;
            load_int = load_int * 32'd10 + 32'(load_value[4*i +: 4]);
        end
    end

    assign load_ok  = load && load_digits_ok && load_int < 32'(MODULUS);
    assign tick     = !pause && pre == PRE_LAST;
    assign wrap_now = tick && !load_ok && (down ? count_bcd == '0 : count_bcd == TOP_BCD);

    assign carry[0]     = 1'b1;
    assign unused_carry = carry[NUM_DIGITS];

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load_ok),
            .load_digit (load_value[4*d +: 4]),
            .wrap_set   (wrap_now),
            .wrap_digit (down ? TOP_BCD[4*d +: 4] : BCD_MIN),
            .step       (tick),
            .down       (down),
            .cin        (carry[d]),
            .value      (digits[d]),
            .cout       (carry[d+1])
        );
        assign count_bcd[4*d +: 4] = digits[d];
    end

    // A valid load restarts the prescaler so the next step is a full period away
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pre  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_now;
            if (load_ok)
                pre <= '0;
            else if (!pause)
                pre <= tick ? '0 : pre + 1'b1;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx == IDX_LAST ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end

    assign muxed_digit = digits[idx];
    assign onehot      = NUM_DIGITS'(1) << idx;

`ifdef BCD_SCAN_LEAD_BLANK_EN
    logic [W-1:0] upper;
    // Everything from the scanned digit upward is zero: that digit is a leading zero
    assign upper    = count_bcd >> {idx, 2'b00};
    assign digit_en = (idx != '0 && upper == '0) ? '0 : onehot;
`else
    assign digit_en = onehot;
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: random and directed stimulus against an integer reference model
module tb_bcd_scan_counter;

    localparam int CLK_DIV = 5;
    localparam int ND      = 2;
    localparam int MOD     = 60;
    localparam int SDIV    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic        down = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_value = '0;
    logic [7:0]  count_bcd;
    logic [3:0]  muxed_digit;
    logic [1:0]  digit_en;
    logic        wrap;
    logic [11:0] count3;
    logic [3:0]  muxed3;
    logic [2:0]  en3;
    logic        wrap3;

    int checks = 0;
    int errors = 0;
    int m_cnt, m_pre, m_cyc, w_cnt, w_pre;
    bit m_wrap, m_tick, m_load, w_wrap;

    always #5 clk = ~clk;

    bcd_scan_counter #(.CLK_DIV_INT(CLK_DIV), .NUM_DIGITS(ND), .MODULUS(MOD), .SCAN_DIV(SDIV)) u_dut (
        .clk(clk), .reset(reset), .pause(pause), .down(down), .load(load), .load_value(load_value),
        .count_bcd(count_bcd), .muxed_digit(muxed_digit), .digit_en(digit_en), .wrap(wrap)
    );

    bcd_scan_counter #(.CLK_DIV_INT(2), .NUM_DIGITS(3), .MODULUS(100), .SCAN_DIV(3)) u_wide (
        .clk(clk), .reset(reset), .pause(1'b0), .down(1'b0), .load(1'b0), .load_value(12'h000),
        .count_bcd(count3), .muxed_digit(muxed3), .digit_en(en3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        if (v[7:4] > 9 || v[3:0] > 9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_pre = 0; m_cyc = 0; m_wrap = 0;
            w_cnt = 0; w_pre = 0; w_wrap = 0;
        end else begin
            m_tick = !pause && m_pre == CLK_DIV - 1;
            m_load = load && bcd_val(load_value) >= 0 && bcd_val(load_value) < MOD;
            m_wrap = m_tick && !m_load && (down ? m_cnt == 0 : m_cnt == MOD - 1);
            if (m_load) begin
                m_cnt = bcd_val(load_value);
                m_pre = 0;
            end else if (!pause) begin
                if (m_tick) m_cnt = down ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
                m_pre = (m_pre + 1) % CLK_DIV;
            end
            m_cyc++;
            w_wrap = w_pre == 1 && w_cnt == 99;
            if (w_pre == 1) w_cnt = (w_cnt + 1) % 100;
            w_pre = (w_pre + 1) % 2;
        end
    end

    always @(negedge clk) begin
        int idx;
        bit blank;
        idx = (m_cyc / SDIV) % ND;
        blank = 0;
`ifdef BCD_SCAN_LEAD_BLANK_EN
        blank = idx > 0 && m_cnt < 10 ** idx;
`endif
        check("count", count_bcd, to_bcd(m_cnt));
        check("wrap", wrap, m_wrap);
        check("muxed", muxed_digit, (m_cnt / 10 ** idx) % 10);
        check("digit_en", digit_en, blank ? 0 : 1 << idx);
        check("count3", count3, to_bcd(w_cnt));
        check("wrap3", wrap3, w_wrap);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_value = v;
        cycles(1);
        load = 1'b0;
    endtask

    initial begin
        cycles(3);
        check("rst_count", count_bcd, 8'h00);
        check("rst_en", digit_en, 2'b01);
        reset = 1'b0;
        cycles(300);
        check("up_300", count_bcd, 8'h00);
        check("up_wrap", wrap, 1'b1);
        down = 1'b1;
        cycles(5);
        check("down_59", count_bcd, 8'h59);
        check("down_wrap", wrap, 1'b1);
        cycles(5);
        check("down_58", count_bcd, 8'h58);
        do_load(8'h10);
        cycles(5);
        check("down_09", count_bcd, 8'h09);
        down = 1'b0;
        do_load(8'h23);
        cycles(2);
        pause = 1'b1;
        cycles(100);
        check("pause_hold", count_bcd, 8'h23);
        pause = 1'b0;
        cycles(2);
        check("resume_wait", count_bcd, 8'h23);
        cycles(1);
        check("resume_tick", count_bcd, 8'h24);
        pause = 1'b1;
        do_load(8'h45);
        check("load_paused", count_bcd, 8'h45);
        do_load(8'h60);
        check("load_60", count_bcd, 8'h45);
        do_load(8'h3A);
        check("load_3a", count_bcd, 8'h45);
        pause = 1'b0;
        for (int i = 0; i < 10 && m_pre != CLK_DIV - 1; i++) cycles(1);
        do_load(8'h12);
        check("load_on_tick", count_bcd, 8'h12);
        pause = 1'b1;
        do_load(8'h07);
        cycles(16);
        do_load(8'h37);
        cycles(3);
        check("pre_reset", count_bcd, 8'h37);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_count", count_bcd, 8'h00);
        check("async_en", digit_en, 2'b01);
        check("async_muxed", muxed_digit, 4'h0);
        check("async_count3", count3, 12'h000);
        cycles(2);
        pause = 1'b0;
        reset = 1'b0;
        repeat (2000) begin
            pause = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 31) == 0) down = ~down;
            load = $urandom_range(0, 15) == 0;
            load_value = $urandom_range(0, 3) == 0 ? 8'($urandom)
                       : {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            cycles(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
